// File: rtl/sha1_pkg.sv
// Shared types, constants and round helpers for the SHA-1 co-processor.
// Optional feature macro used by the top: SHA1_CYCLE_COUNT_EN.
package sha1_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        UPDATE  = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } sha1_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_abcde_t;

    localparam logic [31:0] K_00_19 = 32'h5A82_7999;
    localparam logic [31:0] K_20_39 = 32'h6ED9_EBA1;
    localparam logic [31:0] K_40_59 = 32'h8F1B_BCDC;
    localparam logic [31:0] K_60_79 = 32'hCA62_C1D6;

    localparam logic [31:0] H0_INIT = 32'h6745_2301;
    localparam logic [31:0] H1_INIT = 32'hEFCD_AB89;
    localparam logic [31:0] H2_INIT = 32'h98BA_DCFE;
    localparam logic [31:0] H3_INIT = 32'h1032_5476;
    localparam logic [31:0] H4_INIT = 32'hC3D2_E1F0;

    localparam int LOAD_LAST  = 16;
    localparam int WRITE_LAST = 4;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)      return (b & c) | (~b & d);
        else if (t < 7'd40) return b ^ c ^ d;
        else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
        else                return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        if (t < 7'd20)      return K_00_19;
        else if (t < 7'd40) return K_20_39;
        else if (t < 7'd60) return K_40_59;
        else                return K_60_79;
    endfunction

endpackage

// File: rtl/sha1_copro_p_round.sv
// One combinational SHA-1 round; the top chains UNROLL of these per clock.
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_abcde_t st_i,
    input  logic [31:0] w_i,
    input  logic [6:0]  t_i,
    output sha1_abcde_t st_o
);

    always_comb begin
        st_o.a = rotl(st_i.a, 5) + sha1_f(t_i, st_i.b, st_i.c, st_i.d) + st_i.e
                 + sha1_k(t_i) + w_i;
        st_o.b = st_i.a;
        st_o.c = rotl(st_i.b, 30);
        st_o.d = st_i.c;
        st_o.e = st_i.d;
    end

endmodule

// File: rtl/sha1_copro_p.sv
// SHA-1 co-processor: fetches and pads a message from word-addressed SRAM, hashes
// UNROLL rounds per clock, writes the digest back. SHA1_CYCLE_COUNT_EN adds cycle_count.
module sha1_copro_p
    import sha1_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int UNROLL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       size,
    input  logic [31:0]       output_addr,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
`ifdef SHA1_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam int COMPUTE_LAST = 80 / UNROLL - 1;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("sha1_copro_p: UNROLL must be 1, 2 or 4");
    end

    sha1_state_t state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] blk_q, blk_d;
    logic [31:0] msg_addr_q, msg_addr_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [31:0] size_q, size_d;
    logic [31:0] nwords_q, nwords_d;
    logic [31:0] nblk_q, nblk_d;
    logic [31:0] h_q [5];
    logic [31:0] h_d [5];
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    sha1_abcde_t st_q, st_d;
    logic        done_q, done_d;
    logic [31:0] addr_hold_q;

    logic        start_acc;
    logic [31:0] blk_base;
    logic [31:0] full_words;
    logic [31:0] fetch_addr;
    logic [31:0] wr_addr;
    logic [31:0] addr_full;
    logic        issue_fetch;
    logic [3:0]  cap_idx;
    logic [31:0] cap_g;
    logic [31:0] swapped;
    logic [31:0] cap_word;
    logic [31:0] h_sel;
    logic [6:0]  t_base;
    logic        unused_addr_hi;

    assign mem_clk    = clk;
    assign done       = done_q;
    assign start_acc  = start && (state_q == IDLE || state_q == DONE);
    assign blk_base   = blk_q << 4;
    assign full_words = size_q >> 2;
    assign fetch_addr = msg_addr_q + blk_base + 32'(cnt_q[3:0]);
    assign wr_addr    = out_addr_q + 32'(cnt_q);
    assign issue_fetch = (state_q == LOAD) && (cnt_q < 7'(LOAD_LAST))
                         && ((blk_base + 32'(cnt_q[3:0])) < nwords_q);
    assign cap_idx    = cnt_q[3:0] - 4'd1;
    assign cap_g      = blk_base + 32'(cap_idx);
    assign swapped    = bswap32(mem_read_data);
    assign t_base     = 7'(int'(cnt_q) * UNROLL);
    assign unused_addr_hi = ^addr_full[31:ADDR_W];

    // Word generation for the word whose read data arrives this cycle.
    always_comb begin
        cap_word = 32'h0;
        if (cap_g < nwords_q) begin
            cap_word = swapped;
            if (cap_g == full_words) begin
                case (size_q[1:0])
                    2'd1:    cap_word = {swapped[31:24], 8'h80, 16'h0};
                    2'd2:    cap_word = {swapped[31:16], 8'h80, 8'h0};
                    2'd3:    cap_word = {swapped[31:8], 8'h80};
                    default: cap_word = swapped;
                endcase
            end
        end else if (cap_g == full_words) begin
            cap_word = 32'h8000_0000;
        end else if (cap_g == (nblk_q << 4) - 32'd2) begin
            cap_word = {29'b0, size_q[31:29]};
        end else if (cap_g == (nblk_q << 4) - 32'd1) begin
            cap_word = size_q << 3;
        end
    end

    // Schedule window extended by the UNROLL words needed after this cycle.
    logic [31:0] ext [16+UNROLL];
    always_comb begin
        for (int j = 0; j < 16; j++) ext[j] = w_q[j];
        for (int m = 0; m < UNROLL; m++) begin
            ext[16+m] = rotl(ext[13+m] ^ ext[8+m] ^ ext[2+m] ^ ext[m], 1);
        end
    end

    sha1_abcde_t chain [UNROLL+1];
    assign chain[0] = st_q;
    for (genvar m = 0; m < UNROLL; m++) begin : g_round
        sha1_round u_round (
            .st_i (chain[m]),
            .w_i  (ext[m]),
            .t_i  (t_base + 7'(m)),
            .st_o (chain[m+1])
        );
    end

    always_comb begin
        case (cnt_q[2:0])
            3'd0:    h_sel = h_q[0];
            3'd1:    h_sel = h_q[1];
            3'd2:    h_sel = h_q[2];
            3'd3:    h_sel = h_q[3];
            default: h_sel = h_q[4];
        endcase
    end

    // Unfetched LOAD words and idle cycles leave the address bus where it was.
    always_comb begin
        mem_we         = 1'b0;
        mem_write_data = 32'h0;
        addr_full      = addr_hold_q;
        if (state_q == WRITE) begin
            mem_we         = 1'b1;
            mem_write_data = h_sel;
            addr_full      = wr_addr;
        end else if (issue_fetch) begin
            addr_full = fetch_addr;
        end
        mem_addr = addr_full[ADDR_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blk_d      = blk_q;
        msg_addr_d = msg_addr_q;
        out_addr_d = out_addr_q;
        size_d     = size_q;
        nwords_d   = nwords_q;
        nblk_d     = nblk_q;
        h_d        = h_q;
        w_d        = w_q;
        st_d       = st_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    msg_addr_d = message_addr;
                    out_addr_d = output_addr;
                    size_d     = size;
                    nwords_d   = 32'((33'(size) + 33'd3) >> 2);
                    nblk_d     = 32'((33'(size) + 33'd8) >> 6) + 32'd1;
                    h_d[0]     = H0_INIT;
                    h_d[1]     = H1_INIT;
                    h_d[2]     = H2_INIT;
                    h_d[3]     = H3_INIT;
                    h_d[4]     = H4_INIT;
                    blk_d      = 32'd0;
                    cnt_d      = 7'd0;
                    state_d    = LOAD;
                end else if (state_q == DONE) begin
                    done_d = 1'b1;
                end
            end
            LOAD: begin
                if (cnt_q != 7'd0) w_d[cap_idx] = cap_word;
                if (cnt_q == 7'(LOAD_LAST)) begin
                    st_d    = '{a: h_q[0], b: h_q[1], c: h_q[2], d: h_q[3], e: h_q[4]};
                    cnt_d   = 7'd0;
                    state_d = COMPUTE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            COMPUTE: begin
                st_d = chain[UNROLL];
                for (int j = 0; j < 16; j++) w_d[j] = ext[j+UNROLL];
                if (cnt_q == 7'(COMPUTE_LAST)) begin
                    cnt_d   = 7'd0;
                    state_d = UPDATE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            UPDATE: begin
                h_d[0] = h_q[0] + st_q.a;
                h_d[1] = h_q[1] + st_q.b;
                h_d[2] = h_q[2] + st_q.c;
                h_d[3] = h_q[3] + st_q.d;
                h_d[4] = h_q[4] + st_q.e;
                cnt_d  = 7'd0;
                if (blk_q < nblk_q - 32'd1) begin
                    blk_d   = blk_q + 32'd1;
                    state_d = LOAD;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == 7'(WRITE_LAST)) begin
                    cnt_d   = 7'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 7'd0;
            blk_q       <= 32'd0;
            msg_addr_q  <= 32'd0;
            out_addr_q  <= 32'd0;
            size_q      <= 32'd0;
            nwords_q    <= 32'd0;
            nblk_q      <= 32'd0;
            st_q        <= '0;
            done_q      <= 1'b0;
            addr_hold_q <= 32'd0;
            for (int k = 0; k < 5; k++)  h_q[k] <= 32'd0;
            for (int j = 0; j < 16; j++) w_q[j] <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            msg_addr_q  <= msg_addr_d;
            out_addr_q  <= out_addr_d;
            size_q      <= size_d;
            nwords_q    <= nwords_d;
            nblk_q      <= nblk_d;
            st_q        <= st_d;
            done_q      <= done_d;
            addr_hold_q <= addr_full;
            h_q         <= h_d;
            w_q         <= w_d;
        end
    end

`ifdef SHA1_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start_acc) begin
            cyc_d = 32'd0;
        end else if (state_q != IDLE && !done_q && cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_q <= 32'd0;
        else          cyc_q <= cyc_d;
    end

    assign cycle_count = cyc_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: doc/sha1_copro_p.md
Name: sha1_copro_p

Overview:
- Parametrised next-generation SHA-1 hash co-processor.
- On `start`, reads a message of `size` bytes from word-addressed shared memory starting at `message_addr`, and pads it on the fly.
- Hashes the message in 512-bit blocks, processing UNROLL rounds per clock.
- Writes the 160-bit digest as 5 words at `output_addr`, then raises `done`.
- Sits between the host and the single-port testbench/system SRAM.

Parameters:
- ADDR_W, 16, width of `mem_addr`.
- UNROLL, 1, SHA-1 rounds per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  system clock; rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- message_addr  in  32  word address of the first message word; latched on start.
- size  in  32  message length in bytes; latched on start.
- output_addr  in  32  word address of the first digest word; latched on start.
- done  out  1  hash complete; level signal.
- mem_clk  out  1  memory clock; equal to clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data, valid one mem_clk edge after the address was presented.

Behaviour:
- Reset values: done=0, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE.
- Reset asserted mid-operation aborts the operation immediately; no further writes occur.
- States and transitions:
  - IDLE to LOAD on start. Inputs are latched, H0..H4 are set to 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0, and the block counter is cleared.
  - LOAD: 17 cycles. Word index i runs 0..15, and one address is issued per cycle, addr = message_addr + blk*16 + i. A word is fetched from memory only if its global index g is less than ceil(size/4). Otherwise mem_addr holds and the word is generated locally. The final cycle drains the last read.
  - COMPUTE: 80/UNROLL cycles. A 16-word W window shifts by UNROLL words per cycle, with W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]). a..e are initialised from H.
  - UPDATE: 1 cycle. H += a..e. Next state is LOAD if blk < nblocks-1, else WRITE.
  - WRITE: 5 cycles. mem_we=1 and word k = Hk is written to output_addr+k, with no byte swap.
  - DONE: done=1 and held. A new start clears done and enters LOAD on the same edge.
- start is ignored in LOAD, COMPUTE, UPDATE and WRITE.
- Byte order:
  - Memory words are little-endian.
  - Each word is byte-swapped on fetch: {d[7:0],d[15:8],d[23:16],d[31:24]}.
- Padding, using the global word index g of the swapped word:
  - nblocks = (size+8)/64 + 1, integer division.
  - For g = size/4, keep the leading size%4 bytes, put 0x80 in the next byte and zero the rest. When size%4 = 0 the word is 80000000.
  - For g > size/4, the word is zero, except:
    - word nblocks*16-2 = {29'b0, size[31:29]};
    - word nblocks*16-1 = size<<3.
- Latency: done rises exactly nblocks*(18 + 80/UNROLL) + 6 clocks after the edge that accepts start.
- All arithmetic is 32-bit modulo 2^32.

Optional Feature:
- Macro: SHA1_CYCLE_COUNT_EN.
- When defined:
  - adds output `cycle_count` [31:0], reset to 0;
  - cleared when start is accepted;
  - increments every clock while busy;
  - frozen while done=1;
  - saturates at FFFFFFFF.
- When undefined, the port and the counter do not exist and behaviour is otherwise identical.

Decomposition:
- Package sha1_pkg holds:
  - state enum `sha1_state_t`: IDLE, LOAD, COMPUTE, UPDATE, WRITE, DONE;
  - K constants and H-init constants;
  - functions `sha1_f(t,b,c,d)`, `sha1_k(t)`, `rotl`, `bswap32`.
- Sub-module sha1_round: one combinational round, taking {a,b,c,d,e}, w and t and returning the next {a..e}. It is instantiated UNROLL times in a chain.

Test Plan:
- "abc": mem[0]=00636261, size=3 -> digest words a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d; done after 1*(18+80)+6 = 104 clocks at UNROLL=1.
- size=0 -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709. No memory reads occur: mem_we=0 and mem_addr is static during LOAD.
- Seed 01234567, each word rotl1 of the previous, size=120 (3 blocks) -> must match the behavioural golden model; repeat for sizes 55, 56, 63, 64 and 65 (block-boundary padding).
- UNROLL=4, same vectors -> identical digests; "abc" done after 1*(18+20)+6 = 44 clocks; with SHA1_CYCLE_COUNT_EN, cycle_count=44.
- start pulsed during COMPUTE -> ignored and digest unchanged. reset_n low mid-COMPUTE -> done=0 and mem_we=0 at once. A following clean run of "abc" gives the correct digest.
